// File: rtl/sigma_delta_decimator.sv
// Third-order CIC decimator turning a 1-bit sigma-delta stream into
// signed PCM samples with a one-cycle valid strobe.
module sigma_delta_decimator #(
   parameter int DECIM = 64,
   parameter int OUT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic [OUT_W-1:0] sample_out,
   output logic             sample_valid
);

   localparam int LG    = $clog2(DECIM);
   localparam int ACC_W = 3 * LG + 1;
   // One guard bit keeps +DECIM^3 and -DECIM^3 distinct after the combs.
   localparam int W     = ACC_W + 1;
   localparam int SH    = OUT_W - ACC_W;

   localparam logic signed [OUT_W:0] POS_FS =
      (OUT_W+1)'(1) << (OUT_W - 1);
   localparam logic [OUT_W-1:0] MAX_POS =
      {1'b0, {(OUT_W-1){1'b1}}};

   logic [W-1:0]  i1, i2, i3;
   logic [W-1:0]  i1_n, i2_n, i3_n;
   logic [W-1:0]  step;
   logic [W-1:0]  snap;
   logic [W-1:0]  d1, d2, d3;
   logic [W-1:0]  c1, c2, c3;
   logic [LG-1:0] phase;
   logic          frame_end;
   logic          strobe;
   logic [1:0]    frames;
   logic signed [OUT_W:0] scaled;
   logic [OUT_W-1:0]      sat;

   always_comb begin
      step      = bit_in ? W'(1) : '1;
      i1_n      = i1 + step;
      i2_n      = i2 + i1_n;
      i3_n      = i3 + i2_n;
      frame_end = bit_valid && (phase == LG'(DECIM - 1));
   end

   always_comb begin
      c1     = snap - d1;
      c2     = c1 - d2;
      c3     = c2 - d3;
      scaled = (OUT_W+1)'(signed'(c3)) <<< SH;
      sat    = (scaled == POS_FS) ? MAX_POS : scaled[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i1    <= '0;
         i2    <= '0;
         i3    <= '0;
         phase <= '0;
      end else if (bit_valid) begin
         i1    <= i1_n;
         i2    <= i2_n;
         i3    <= i3_n;
         phase <= phase + LG'(1);
      end
   end

   // Snapshot frees the combs from integrators still moving next cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap   <= '0;
         strobe <= 1'b0;
      end else begin
         strobe <= frame_end;
         if (frame_end)
            snap <= i3_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d1           <= '0;
         d2           <= '0;
         d3           <= '0;
         frames       <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (strobe) begin
            d1 <= snap;
            d2 <= c1;
            d3 <= c2;
            if (frames != 2'd3)
               frames <= frames + 2'd1;
            else begin
               sample_out   <= sat;
               sample_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Directed bench for sigma_delta_decimator: steady-state values,
// warm-up suppression, 2-cycle latency, gaps and mid-frame reset.
module tb_sigma_delta_decimator;

   localparam int D  = 64;
   localparam int OW = 24;
   localparam int NF = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          bit_in = 1'b0;
   logic          bit_valid = 1'b0;
   logic [OW-1:0] sample_out;
   logic          sample_valid;

   sigma_delta_decimator #(.DECIM(D), .OUT_W(OW)) dut (
      .clk          (clk),
      .reset        (reset),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .sample_out   (sample_out),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad = 0;
   int nbits = 0;
   int fe_q[$];
   int vc_q[$];
   logic [OW-1:0] vv_q[$];

   always @(negedge clk)
      if (sample_valid) begin
         vc_q.push_back(cyc);
         vv_q.push_back(sample_out);
      end

   typedef struct {
      string         name;
      logic [3:0]    pat;
      int            plen;
      int            gmax;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic pbit(input vec_t v, input int i);
      logic [3:0] p;
      p = v.pat;
      return p[i % v.plen];
   endfunction

   task automatic send(input logic b, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1 bit_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      bit_valid = 1'b1;
      bit_in    = b;
      nbits++;
      if (nbits % D == 0)
         fe_q.push_back(cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 bit_valid = 1'b0;
      end
   endtask

   task automatic stream(input vec_t v, input int n);
      for (int i = 0; i < n; i++)
         send(pbit(v, nbits),
              v.gmax > 0 ? int'($urandom_range(0, v.gmax)) : 0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      fe_q.delete();
      vc_q.delete();
      vv_q.delete();
      nbits = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b0;
      bit_valid = 1'b0;
      release_reset();
   endtask

   task automatic check_run(input vec_t v, input int nf);
      chk({v.name, " count"}, 32'(vc_q.size()), 32'(nf - 3));
      for (int k = 0; k < vc_q.size() && k < nf - 3; k++) begin
         chk({v.name, " value"}, 32'(vv_q[k]), 32'(v.exp));
         if (k + 3 < fe_q.size())
            chk({v.name, " latency"}, 32'(vc_q[k]),
                32'(fe_q[k+3] + 1));
      end
   endtask

   initial begin
      vecs[0] = '{"ones",  4'b0001, 1, 0, 24'h7FFFFF};
      vecs[1] = '{"zeros", 4'b0000, 1, 0, 24'h800000};
      vecs[2] = '{"alt",   4'b0001, 2, 0, 24'h000000};
      vecs[3] = '{"q1000", 4'b0001, 4, 0, 24'hC00000};
      vecs[4] = '{"gaps",  4'b0001, 4, 5, 24'hC00000};

      #2 reset = 1'b0;
      #6;
      chk("rst out", 32'(sample_out), 32'h0);
      chk("rst valid", 32'(sample_valid), 32'h0);
      release_reset();

      for (int t = 0; t < 5; t++) begin
         do_reset();
         stream(vecs[t], NF * D);
         idle(8);
         check_run(vecs[t], NF);
      end

      do_reset();
      stream(vecs[0], 4 * D + 30);
      chk("pre count", 32'(vc_q.size()), 32'd1);
      if (vv_q.size() > 0)
         chk("pre value", 32'(vv_q[0]), 32'h7FFFFF);
      @(negedge clk);
      reset     = 1'b0;
      bit_valid = 1'b0;
      #1;
      chk("mid out", 32'(sample_out), 32'h0);
      chk("mid valid", 32'(sample_valid), 32'h0);
      release_reset();
      stream(vecs[0], NF * D);
      idle(8);
      check_run(vecs[0], NF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
